// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: none (types only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int PC_INC      = 4;
   localparam int INSTR_W_DEF = 32;
   localparam int PC_W_DEF    = 8;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   // IF/ID payload at the default widths; the stage declares a same-shaped
   // struct locally so that WIDTH/INSTR_W overrides still line up.
   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [PC_W_DEF-1:0]    pc;
      logic [PC_W_DEF-1:0]    pc_plus4;
   } if_id_bundle_t;

endpackage

// File: rtl/if_id_reg.sv
// Valid/data pipeline register with load, stall-hold and flush.
// Latency: one edge from load_i to valid_o/data_o.
// Backpressure: contents hold while valid and stall_i; flush_i beats load_i.
module if_id_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic         flush_i,
   input  logic         stall_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // Flush drops the entry, load refills it, an unstalled entry is consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (valid_q && !stall_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: drives imem around the PC register and fills IF/ID.
// Latency: an accepted response lands in IF/ID on the following edge.
// Backpressure: stall with IF/ID full parks one response in HOLD (no request).
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int WIDTH   = 8,            // byte address width, at least 3
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   pc,
   output logic [WIDTH-1:0]   pc_next,
   output logic               imem_req,
   output logic [WIDTH-1:0]   imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect,
   input  logic [WIDTH-1:0]   redirect_target,
   input  logic               stall,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [WIDTH-1:0]   id_pc,
   output logic [WIDTH-1:0]   id_pc_plus4
);

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [WIDTH-1:0]   pc;
      logic [WIDTH-1:0]   pc_plus4;
   } bundle_t;

   fetch_state_e     state_q, state_d;
   logic [WIDTH-1:0] drain_q, drain_d;
   bundle_t          hold_q, hold_d;
   bundle_t          load_dat;
   bundle_t          id_dat;
   logic             load;
   logic             flush;
   logic [WIDTH-1:0] pc_plus4;

   // Wraps modulo 2^WIDTH.
   assign pc_plus4 = pc + WIDTH'(PC_INC);

   // State, stale-request address and parked response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         drain_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         hold_q  <= hold_d;
      end
   end

   // Next state, memory request, next PC and IF/ID load/flush controls.
   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      hold_d    = hold_q;
      pc_next   = pc;
      imem_req  = 1'b0;
      imem_addr = pc;
      load      = 1'b0;
      load_dat  = '0;
      flush     = 1'b0;

      case (state_q)
         FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               pc_next = redirect_target;
               flush   = 1'b1;
               hold_d  = '0;
               // Without a response this cycle the old request is still
               // in flight and must be absorbed before refetching.
               if (!imem_valid) begin
                  drain_d = pc;
                  state_d = DRAIN;
               end
            end else if (imem_valid) begin
               pc_next = pc_plus4;
               if (!id_valid || !stall) begin
                  load     = 1'b1;
                  load_dat = '{instr: imem_rdata, pc: pc, pc_plus4: pc_plus4};
               end else begin
                  hold_d  = '{instr: imem_rdata, pc: pc, pc_plus4: pc_plus4};
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_next = redirect_target;
               flush   = 1'b1;
               hold_d  = '0;
               state_d = FETCH;
            end else if (!stall) begin
               load     = 1'b1;
               load_dat = hold_q;
               state_d  = FETCH;
            end
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = drain_q;
            if (redirect) begin
               pc_next = redirect_target;
               flush   = 1'b1;
               hold_d  = '0;
            end
            if (imem_valid) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      // The PC register and memory are held in reset by the same signal.
      if (reset) begin
         imem_req = 1'b0;
         pc_next  = '0;
      end
   end

   if_id_reg #(
      .W($bits(bundle_t))
   ) u_if_id (
      .clk    (clk),
      .reset  (reset),
      .load_i (load),
      .flush_i(flush),
      .stall_i(stall),
      .data_i (load_dat),
      .valid_o(id_valid),
      .data_o (id_dat)
   );

   assign id_instr    = id_dat.instr;
   assign id_pc       = id_dat.pc;
   assign id_pc_plus4 = id_dat.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic [7:0]  pc;
   logic [7:0]  pc_next;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_valid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [7:0]  redirect_target;
   logic        stall;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [7:0]  id_pc;
   logic [7:0]  id_pc_plus4;

   int checks;
   int errors;

   // memory model: response after mem_lat waiting cycles
   int          mem_lat;
   int          mem_cnt;
   logic        rd_override;
   logic [31:0] rd_val;
   // PC register model with a bench-side load
   logic        pc_force;
   logic [7:0]  pc_force_val;

   fetch_stage #(.WIDTH(8), .INSTR_W(32)) dut (
      .clk            (clk),
      .reset          (reset),
      .pc             (pc),
      .pc_next        (pc_next),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_valid     (imem_valid),
      .imem_rdata     (imem_rdata),
      .redirect       (redirect),
      .redirect_target(redirect_target),
      .stall          (stall),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_valid = imem_req && (mem_cnt == mem_lat);
   assign imem_rdata = rd_override ? rd_val : {24'h0C0DE0, imem_addr};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mem_cnt <= 0;
      else if (imem_valid || pc_force) mem_cnt <= 0;
      else if (imem_req) mem_cnt <= mem_cnt + 1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc <= 8'h00;
      else if (pc_force) pc <= pc_force_val;
      else pc <= pc_next;
   end

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %h want 0", id_valid); end
      checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_id_instr got %h want 0", id_instr); end
      checks++; if (id_pc !== 8'h00) begin errors++; $display("FAIL rst_id_pc got %h want 00", id_pc); end
      checks++; if (id_pc_plus4 !== 8'h00) begin errors++; $display("FAIL rst_id_pc_plus4 got %h want 00", id_pc_plus4); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %h want 0", imem_req); end
      checks++; if (pc_next !== 8'h00) begin errors++; $display("FAIL rst_pc_next got %h want 00", pc_next); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_zero_wait();
      mem_lat = 0;
      stall   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (imem_addr !== 8'(i*4)) begin errors++; $display("FAIL zw_addr%0d got %h want %h", i, imem_addr, 8'(i*4)); end
         checks++; if (pc_next !== 8'((i+1)*4)) begin errors++; $display("FAIL zw_pc_next%0d got %h want %h", i, pc_next, 8'((i+1)*4)); end
         @(negedge clk);
         checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL zw_id_valid%0d got %h want 1", i, id_valid); end
         checks++; if (id_pc !== 8'(i*4)) begin errors++; $display("FAIL zw_id_pc%0d got %h want %h", i, id_pc, 8'(i*4)); end
         checks++; if (id_instr !== {24'h0C0DE0, 8'(i*4)}) begin errors++; $display("FAIL zw_id_instr%0d got %h want %h", i, id_instr, {24'h0C0DE0, 8'(i*4)}); end
      end
   endtask

   task automatic test_latency();
      // pc is 0C here; load 10 and restart the memory counter
      mem_lat      = 3;
      pc_force     = 1'b1;
      pc_force_val = 8'h10;
      @(negedge clk);
      pc_force = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL lat_req%0d got %h want 1", k, imem_req); end
         checks++; if (imem_addr !== 8'h10) begin errors++; $display("FAIL lat_addr%0d got %h want 10", k, imem_addr); end
         checks++; if (pc_next !== 8'h10) begin errors++; $display("FAIL lat_pc_next%0d got %h want 10", k, pc_next); end
         @(negedge clk);
      end
      #1;
      checks++; if (pc_next !== 8'h14) begin errors++; $display("FAIL lat_pc_next_done got %h want 14", pc_next); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL lat_id_valid_pre got %h want 0", id_valid); end
      @(negedge clk);
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL lat_id_valid got %h want 1", id_valid); end
      checks++; if (id_pc !== 8'h10) begin errors++; $display("FAIL lat_id_pc got %h want 10", id_pc); end
      checks++; if (id_instr !== 32'h0C0DE010) begin errors++; $display("FAIL lat_id_instr got %h want 0C0DE010", id_instr); end
   endtask

   task automatic test_hold();
      // IF/ID holds pc 10; pc is 14
      mem_lat = 1;
      stall   = 1'b1;
      #1;
      checks++; if (pc_next !== 8'h14) begin errors++; $display("FAIL hold_wait_pc_next got %h want 14", pc_next); end
      @(negedge clk);
      rd_override = 1'b1;
      rd_val      = 32'hDEADBEEF;
      #1;
      checks++; if (pc_next !== 8'h18) begin errors++; $display("FAIL hold_cap_pc_next got %h want 18", pc_next); end
      @(negedge clk);
      rd_override = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d got %h want 0", k, imem_req); end
         checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL hold_id_valid%0d got %h want 1", k, id_valid); end
         checks++; if (id_pc !== 8'h10) begin errors++; $display("FAIL hold_id_pc%0d got %h want 10", k, id_pc); end
         checks++; if (id_instr !== 32'h0C0DE010) begin errors++; $display("FAIL hold_id_instr%0d got %h want 0C0DE010", k, id_instr); end
         checks++; if (pc_next !== 8'h18) begin errors++; $display("FAIL hold_pc_next%0d got %h want 18", k, pc_next); end
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_rel_req got %h want 0", imem_req); end
      @(negedge clk);
      checks++; if (id_instr !== 32'hDEADBEEF) begin errors++; $display("FAIL hold_out_instr got %h want DEADBEEF", id_instr); end
      checks++; if (id_pc !== 8'h14) begin errors++; $display("FAIL hold_out_pc got %h want 14", id_pc); end
      checks++; if (id_pc_plus4 !== 8'h18) begin errors++; $display("FAIL hold_out_pc4 got %h want 18", id_pc_plus4); end
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL hold_out_valid got %h want 1", id_valid); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_out_req got %h want 1", imem_req); end
      checks++; if (imem_addr !== 8'h18) begin errors++; $display("FAIL hold_out_addr got %h want 18", imem_addr); end
   endtask

   task automatic test_redirect_drain();
      // keep IF/ID full while the request at 20 starts
      mem_lat      = 2;
      stall        = 1'b1;
      pc_force     = 1'b1;
      pc_force_val = 8'h20;
      @(negedge clk);
      pc_force        = 1'b0;
      redirect        = 1'b1;
      redirect_target = 8'h40;
      #1;
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rd_pre_valid got %h want 1", id_valid); end
      checks++; if (imem_addr !== 8'h20) begin errors++; $display("FAIL rd_addr got %h want 20", imem_addr); end
      checks++; if (pc_next !== 8'h40) begin errors++; $display("FAIL rd_pc_next got %h want 40", pc_next); end
      @(negedge clk);
      redirect = 1'b0;
      stall    = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_drain_valid%0d got %h want 0", k, id_valid); end
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rd_drain_req%0d got %h want 1", k, imem_req); end
         checks++; if (imem_addr !== 8'h20) begin errors++; $display("FAIL rd_drain_addr%0d got %h want 20", k, imem_addr); end
         checks++; if (pc_next !== 8'h40) begin errors++; $display("FAIL rd_drain_pc_next%0d got %h want 40", k, pc_next); end
         @(negedge clk);
      end
      mem_lat = 0;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_stale_valid got %h want 0", id_valid); end
      checks++; if (imem_addr !== 8'h40) begin errors++; $display("FAIL rd_new_addr got %h want 40", imem_addr); end
      checks++; if (pc_next !== 8'h44) begin errors++; $display("FAIL rd_new_pc_next got %h want 44", pc_next); end
      @(negedge clk);
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rd_new_valid got %h want 1", id_valid); end
      checks++; if (id_pc !== 8'h40) begin errors++; $display("FAIL rd_new_id_pc got %h want 40", id_pc); end
      checks++; if (id_instr !== 32'h0C0DE040) begin errors++; $display("FAIL rd_new_instr got %h want 0C0DE040", id_instr); end
   endtask

   task automatic test_redirect_stall_wrap();
      // IF/ID holds 40, pc 44, zero-wait response arriving together with redirect
      stall           = 1'b1;
      redirect        = 1'b1;
      redirect_target = 8'hFC;
      #1;
      checks++; if (pc_next !== 8'hFC) begin errors++; $display("FAIL wr_pc_next got %h want FC", pc_next); end
      @(negedge clk);
      redirect = 1'b0;
      stall    = 1'b0;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL wr_flush_valid got %h want 0", id_valid); end
      checks++; if (imem_addr !== 8'hFC) begin errors++; $display("FAIL wr_addr got %h want FC", imem_addr); end
      checks++; if (pc_next !== 8'h00) begin errors++; $display("FAIL wr_wrap_pc_next got %h want 00", pc_next); end
      @(negedge clk);
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL wr_valid got %h want 1", id_valid); end
      checks++; if (id_pc !== 8'hFC) begin errors++; $display("FAIL wr_id_pc got %h want FC", id_pc); end
      checks++; if (id_pc_plus4 !== 8'h00) begin errors++; $display("FAIL wr_id_pc4 got %h want 00", id_pc_plus4); end
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wr_next_addr got %h want 00", imem_addr); end
   endtask

   task automatic test_reset_mid_hold();
      // IF/ID holds FC, pc 00; stalled zero-wait response parks in HOLD
      stall = 1'b1;
      #1;
      checks++; if (pc_next !== 8'h04) begin errors++; $display("FAIL rh_pc_next got %h want 04", pc_next); end
      @(negedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rh_hold_req got %h want 0", imem_req); end
      reset = 1'b1;
      #1;
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rh_valid got %h want 0", id_valid); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rh_req got %h want 0", imem_req); end
      checks++; if (pc_next !== 8'h00) begin errors++; $display("FAIL rh_pc_next_rst got %h want 00", pc_next); end
      @(negedge clk);
      reset = 1'b0;
      stall = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rh_rel_req got %h want 1", imem_req); end
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rh_rel_addr got %h want 00", imem_addr); end
      checks++; if (pc_next !== 8'h04) begin errors++; $display("FAIL rh_rel_pc_next got %h want 04", pc_next); end
      @(negedge clk);
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rh_rel_valid got %h want 1", id_valid); end
      checks++; if (id_pc !== 8'h00) begin errors++; $display("FAIL rh_rel_id_pc got %h want 00", id_pc); end
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      reset           = 1'b1;
      redirect        = 1'b0;
      redirect_target = 8'h00;
      stall           = 1'b0;
      mem_lat         = 0;
      rd_override     = 1'b0;
      rd_val          = 32'h0;
      pc_force        = 1'b0;
      pc_force_val    = 8'h00;

      test_reset();
      test_zero_wait();
      test_latency();
      test_hold();
      test_redirect_drain();
      test_redirect_stall_wrap();
      test_reset_mid_hold();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
